dmem_line_ctrl: RTL and testbench
=================================

# dmem_line_ctrl

Line-granular data memory with programmable access latency, sitting directly downstream of the L1 data cache controller on its 256-bit memory port. Accepts one read or write of a full 32-byte line per transaction. Returns a single-cycle acknowledge after a fixed latency. Holds read data stable afterwards so the cache can refill on the cycle following the acknowledge.

## Interface
Parameters:
- LATENCY, 10: cycles from request acceptance to ack_o; legal range 2..255.
- DEPTH, 512: number of 256-bit lines; power of two.

Ports:
- clk_i  in  1  system clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- addr_i  in  32  byte address. Line index = addr_i[$clog2(DEPTH)+4:5]; bits [4:0] ignored.
- data_i  in  256  write line.
- enable_i  in  1  request valid, level-sensitive.
- write_i  in  1  1 = write, 0 = read; sampled with enable_i.
- data_o  out  256  read line, registered.
- ack_o  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, BUSY, DONE (enum in package).
- IDLE: enable_i=1 at a rising edge accepts the request.
  - Capture addr_i line index, write_i and data_i into registers.
  - Load counter with LATENCY-2; go to BUSY.
  - Later changes to addr_i, write_i or data_i during the transaction are ignored.
- BUSY: counter decrements each cycle.
  - If enable_i=0 at any edge: abort. No ack, no array write; go to IDLE.
  - When counter reaches 0 with enable_i=1: go to DONE.
- DONE (ack_o=1 for exactly this cycle):
  - Read: array[line] is loaded into data_o at the edge leaving DONE. data_o is also driven combinationally valid during DONE, via a bypass mux.
  - Write: the captured line is written to the array at the edge leaving DONE; data_o is unchanged.
  - Next state is always IDLE.
- A request present in the cycle after DONE starts a new transaction. This covers the cache holding enable_i high from write-back into refill. When that new request is spurious, it is aborted by enable_i falling.
- data_o holds the last completed read until the next read completes. It is not affected by writes or aborts.
- Array contents are not reset.

## Timing
- Reset values: ack_o=0, data_o=0, state IDLE, counter 0.
- Reset asserted mid-transaction: the transaction is discarded and the array is not written.
- Accept edge = cycle 0. ack_o is high in cycle LATENCY-1 after acceptance, i.e. LATENCY edges after the request is first seen.
- Back-to-back throughput: one transaction per LATENCY+1 cycles (DONE to IDLE, then re-accept).
- Read data is valid in the ack cycle and in every following cycle until the next read ack.
- Write completion: a read issued after a write's ack returns the new data. There is no forwarding hazard because only one transaction is outstanding.

## Configuration
- DMEM_PERF_EN:
  - Defined: adds outputs rd_cnt_o[31:0], wr_cnt_o[31:0] and abort_cnt_o[31:0].
    - Each counts completed reads, completed writes and aborted transactions respectively.
    - Counters increment at the edge leaving DONE, or at the abort edge.
    - Counters saturate at 32'hFFFF_FFFF and reset to 0.
  - Undefined: these ports and the counters do not exist; behaviour is otherwise identical.

## Structure
- Package dmem_pkg:
  - LINE_W=256, OFFSET_W=5.
  - State enum dmem_state_t {IDLE, BUSY, DONE}.
  - Latency counter width constant (8).
- One sub-module, dmem_line_array: synchronous-write, asynchronous-read storage of DEPTH x LINE_W, with ports clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
- FSM, counter and output registers live in dmem_line_ctrl.

## Test plan
- Reset then read of line 3 with LATENCY=10 -> ack_o high exactly in cycle 9 after accept; data_o = preloaded pattern; data_o stable for 5 more cycles.
- Write 256'hA5.. to addr 0x0000_0060, then read 0x0000_007C -> read returns 256'hA5.. (same line, offset ignored).
- Write-back then refill with enable_i held high across the ack; write_i 1 then 0; addresses differ -> two acks; array updated; data_o = refill line.
- Read accepted, enable_i dropped in cycle 4 -> no ack_o; data_o unchanged; next request accepted normally.
- rst_i pulsed low mid-BUSY of a write -> ack_o=0, data_o=0, target line keeps its old contents.
- With DMEM_PERF_EN: 3 reads, 2 writes, 1 abort -> rd_cnt_o=3, wr_cnt_o=2, abort_cnt_o=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-granular data memory.
// Optional feature macro used by dmem_line_ctrl: DMEM_PERF_EN.
package dmem_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Saturating increment for the 32-bit event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// DEPTH x LINE_W line storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH];

    // Line write on the clock edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory controller with programmable access latency.
// One outstanding 32-byte line transaction; single-cycle ack after LATENCY
// edges; read data held until the next read completes.
// Optional macro DMEM_PERF_EN adds saturating read/write/abort counters.
module dmem_line_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o,
    output logic [31:0]       abort_cnt_o
`endif
);

    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 2);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     line_q, line_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;

    logic              arr_we;
    logic [LINE_W-1:0] arr_rdata;
    logic              abort;
    logic              rd_done;
    logic              wr_done;

    // Byte offset and address bits above the line index are don't-care.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:AW+OFFSET_W], addr_i[OFFSET_W-1:0]};

    dmem_line_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .waddr_i (line_q),
        .wdata_i (wdata_q),
        .raddr_i (line_q),
        .rdata_o (arr_rdata)
    );

    // Next-state logic: accept, count down / abort, complete.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        arr_we  = 1'b0;
        abort   = 1'b0;
        rd_done = 1'b0;
        wr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    line_d  = addr_i[AW+OFFSET_W-1:OFFSET_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!enable_i) begin
                    abort   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (wr_q) begin
                    arr_we  = 1'b1;
                    wr_done = 1'b1;
                end else begin
                    rdata_d = arr_rdata;
                    rd_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counter, captured request and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign ack_o = ack_q;
    // Read data is bypassed straight from the array during the ack cycle,
    // then held in rdata_q from the edge leaving DONE onwards.
    assign data_o = (state_q == DONE && !wr_q) ? arr_rdata : rdata_q;

`ifdef DMEM_PERF_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] abort_cnt_q, abort_cnt_d;

    // Saturating event counters, stepped at completion or abort edges.
    always_comb begin
        rd_cnt_d    = rd_done ? sat_inc32(rd_cnt_q)    : rd_cnt_q;
        wr_cnt_d    = wr_done ? sat_inc32(wr_cnt_q)    : wr_cnt_q;
        abort_cnt_d = abort   ? sat_inc32(abort_cnt_q) : abort_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            abort_cnt_q <= '0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign abort_cnt_o = abort_cnt_q;
`else
    logic unused_events;
    assign unused_events = ^{abort, rd_done, wr_done};
`endif

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Self-checking bench for dmem_line_ctrl (LATENCY=10, DEPTH=512).
// Build with DMEM_PERF_EN defined to also check the event counters.
module tb_dmem_line_ctrl;

    localparam int unsigned LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr;
    logic [255:0] wdat;
    logic         en;
    logic         wr;
    logic [255:0] data_o;
    logic         ack_o;
`ifdef DMEM_PERF_EN
    logic [31:0]  rd_cnt, wr_cnt, ab_cnt;
`endif

    int nvec  = 0;
    int nfail = 0;

    dmem_line_ctrl #(
        .LATENCY (LAT),
        .DEPTH   (512)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .addr_i   (addr),
        .data_i   (wdat),
        .enable_i (en),
        .write_i  (wr),
        .data_o   (data_o),
        .ack_o    (ack_o)
`ifdef DMEM_PERF_EN
        ,
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .abort_cnt_o (ab_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string name, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One full transaction; request fields are scrambled after acceptance to
    // prove they are captured. Returns at the falling edge of the ack cycle.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [255:0] d,
                           output int ack_cyc);
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; wdat = d;
        @(posedge clk);
        ack_cyc = -1;
        for (int c = 0; c < int'(LAT) + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr = ~w; addr = a ^ 32'h0000_0020; wdat = ~d;
            end
            if (ack_o) begin
                ack_cyc = c;
                break;
            end
        end
        en = 1'b0;
    endtask

    // Transaction dropped by enable falling; reports whether any ack appeared.
    task automatic abort_txn(input logic w, input logic [31:0] a, input logic [255:0] d,
                             input int drop_cyc, output logic seen);
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; wdat = d;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 0; c < drop_cyc; c++) begin
            @(negedge clk);
            if (ack_o) seen = 1'b1;
        end
        en = 1'b0;
        for (int c = 0; c < int'(LAT) + 2; c++) begin
            @(negedge clk);
            if (ack_o) seen = 1'b1;
        end
    endtask

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [255:0] pa, p2, px, py, pw, junk, d1;
        int  acyc, a0, a1, nack;
        logic seen;

        pa   = {32{8'hA5}};
        p2   = {8{32'h0123_4567}};
        px   = {4{64'hDEAD_BEEF_0000_FFFF}};
        py   = {16{16'h5A3C}};
        pw   = {8{32'hCAFE_F00D}};
        junk = {8{32'hBAD0_BAD0}};

        vecs[0] = '{1'b1, 32'h0000_0060, pa, 256'h0};   // write line 3, data_o still reset value
        vecs[1] = '{1'b0, 32'h0000_007C, '0, pa};       // read line 3 via different offset
        vecs[2] = '{1'b1, 32'h0000_0040, p2, pa};       // write line 2, data_o unchanged
        vecs[3] = '{1'b0, 32'h0000_0045, '0, p2};
        vecs[4] = '{1'b1, 32'h0000_3FE0, px, p2};       // last line (511)
        vecs[5] = '{1'b0, 32'h0000_3FFF, '0, px};
        vecs[6] = '{1'b0, 32'h0000_4060, '0, pa};       // bits above the index ignored -> line 3
        vecs[7] = '{1'b1, 32'h0000_0060, py, pa};       // overwrite line 3
        vecs[8] = '{1'b0, 32'h0000_0060, '0, py};

        rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdat = '0;
        repeat (2) @(negedge clk);
        check_vec("reset_ack", {255'd0, ack_o}, 256'd0);
        check_vec("reset_data", data_o, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("post_reset_ack", {255'd0, ack_o}, 256'd0);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].w, vecs[i].a, vecs[i].d, acyc);
            check_int($sformatf("v%0d_ack_cycle", i), acyc, int'(LAT) - 1);
            check_vec($sformatf("v%0d_data_ack", i), data_o, vecs[i].exp);
            repeat (5) @(negedge clk);
            check_vec($sformatf("v%0d_data_hold", i), data_o, vecs[i].exp);
            check_vec($sformatf("v%0d_ack_low", i), {255'd0, ack_o}, 256'd0);
        end

        // Write-back then refill with enable held high across the first ack.
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_00A0; wdat = pw;
        @(posedge clk);
        nack = 0; a0 = -1; a1 = -1; d1 = '0;
        for (int c = 0; c < 3 * int'(LAT); c++) begin
            @(negedge clk);
            if (ack_o) begin
                if (nack == 0) begin
                    a0 = c; wr = 1'b0; addr = 32'h0000_0060; wdat = '0;
                end else if (nack == 1) begin
                    a1 = c; d1 = data_o; en = 1'b0;
                end
                nack++;
            end
        end
        en = 1'b0;
        check_int("b2b_ack_count", nack, 2);
        check_int("b2b_first_ack", a0, int'(LAT) - 1);
        check_int("b2b_second_ack", a1, 2 * int'(LAT));
        check_vec("b2b_refill_data", d1, py);
        check_vec("b2b_refill_hold", data_o, py);
        run_txn(1'b0, 32'h0000_00A0, '0, acyc);
        check_vec("b2b_writeback_stored", data_o, pw);

        // Read aborted mid-BUSY: no ack, data_o unchanged, next request fine.
        abort_txn(1'b0, 32'h0000_0060, '0, 4, seen);
        check_vec("abort_rd_no_ack", {255'd0, seen}, 256'd0);
        check_vec("abort_rd_data", data_o, pw);
        // Write aborted mid-BUSY: array must not be written.
        abort_txn(1'b1, 32'h0000_00A0, junk, 3, seen);
        check_vec("abort_wr_no_ack", {255'd0, seen}, 256'd0);
        run_txn(1'b0, 32'h0000_0060, '0, acyc);
        check_int("after_abort_ack", acyc, int'(LAT) - 1);
        check_vec("after_abort_data", data_o, py);
        run_txn(1'b0, 32'h0000_00A0, '0, acyc);
        check_vec("abort_wr_not_stored", data_o, pw);

        // Reset pulsed during a write: outputs clear, line keeps old contents.
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0060; wdat = junk;
        @(posedge clk);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_vec("rst_mid_ack", {255'd0, ack_o}, 256'd0);
        check_vec("rst_mid_data", data_o, 256'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        check_vec("rst_mid_no_late_ack", {255'd0, ack_o}, 256'd0);

        // Post-reset mix: 3 reads, 2 writes, 1 abort.
        run_txn(1'b0, 32'h0000_0060, '0, acyc);
        check_vec("rst_line_kept", data_o, py);
        run_txn(1'b1, 32'h0000_00A0, px, acyc);
        run_txn(1'b1, 32'h0000_0040, pa, acyc);
        run_txn(1'b0, 32'h0000_0040, '0, acyc);
        check_vec("mix_rd_line2", data_o, pa);
        run_txn(1'b0, 32'h0000_00A0, '0, acyc);
        check_vec("mix_rd_line5", data_o, px);
        abort_txn(1'b0, 32'h0000_0040, '0, 2, seen);
        check_vec("mix_abort_data", data_o, px);
`ifdef DMEM_PERF_EN
        check_int("perf_rd_cnt", int'(rd_cnt), 3);
        check_int("perf_wr_cnt", int'(wr_cnt), 2);
        check_int("perf_abort_cnt", int'(ab_cnt), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
